// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state encoding and default sizes for the button event generator
// Contents: state_t (S_IDLE, S_WAIT_HOLD, S_REPEAT; 2'd3 is illegal and recovers to S_IDLE),
//           N_BTN_DEF / CODE_W_DEF default widths used by btn_event_gen
package btn_pkg;
  localparam int N_BTN_DEF  = 5;
  localparam int CODE_W_DEF = 3;
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_HOLD = 2'd1,
    S_REPEAT    = 2'd2
  } state_t;
endpackage

// File: rtl/btn_repeat_fsm.sv
// btn_repeat_fsm: per-button press / hold / auto-repeat FSM with its own hold/repeat counter
// Ports: clk    - system clock
//        rst    - asynchronous active-low reset
//        lvl    - debounced button level, 1 = pressed
//        ev     - combinational event request, registered into the pend queue by the parent
//        ev_rep - kind of the requested event, 0 = initial press, 1 = auto-repeat
//        held   - registered, 1 while the FSM is outside S_IDLE
module btn_repeat_fsm
  import btn_pkg::*;
#(
  parameter int HOLD_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000,
  parameter int CNT_W    = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic ev,
  output logic ev_rep,
  output logic held
);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_hold_done;
  logic               w_rep_done;
  assign w_hold_done = r_cnt == CNT_W'(HOLD_CYC - 1);
  assign w_rep_done  = r_cnt == CNT_W'(REP_CYC - 1);
  // The event is raised in the cycle before the edge so the parent's pend bit sets on that edge
  assign ev = lvl && (r_state == S_IDLE ||
                      (r_state == S_WAIT_HOLD && w_hold_done) ||
                      (r_state == S_REPEAT && w_rep_done));
  assign ev_rep = r_state != S_IDLE;
  // held mirrors the next state: every branch leaves IDLE exactly when lvl is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      held    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= lvl ? S_WAIT_HOLD : S_IDLE;
          r_cnt   <= '0;
          held    <= lvl;
        end
        S_WAIT_HOLD: begin
          r_state <= !lvl ? S_IDLE : w_hold_done ? S_REPEAT : S_WAIT_HOLD;
          r_cnt   <= (!lvl || w_hold_done) ? '0 : r_cnt + CNT_W'(1);
          held    <= lvl;
        end
        S_REPEAT: begin
          r_state <= lvl ? S_REPEAT : S_IDLE;
          r_cnt   <= (!lvl || w_rep_done) ? '0 : r_cnt + CNT_W'(1);
          held    <= lvl;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          held    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: turns debounced button levels into one-cycle press / auto-repeat key events
// Ports: clk        - system clock
//        rst        - asynchronous active-low reset
//        btn_lvl    - debounced button levels, 1 = pressed
//        key_valid  - one-cycle event strobe
//        key_code   - index of the button owning the event (valid with key_valid)
//        key_repeat - 0 = initial press, 1 = auto-repeat (valid with key_valid)
//        btn_held   - 1 while that button's FSM is outside IDLE
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int N_BTN    = N_BTN_DEF,
  parameter int CODE_W   = CODE_W_DEF,
  parameter int HOLD_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000,
  parameter int CNT_W    = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_lvl,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_repeat,
  output logic [N_BTN-1:0]  btn_held
);
  logic [N_BTN-1:0]  w_ev;
  logic [N_BTN-1:0]  w_ev_rep;
  logic [N_BTN-1:0]  w_gnt;
  logic [CODE_W-1:0] w_idx;
  logic [N_BTN-1:0]  r_pend;
  logic [N_BTN-1:0]  r_pend_rep;
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_repeat_fsm #(
      .HOLD_CYC (HOLD_CYC),
      .REP_CYC  (REP_CYC),
      .CNT_W    (CNT_W)
    ) u_fsm (
      .clk    (clk),
      .rst    (rst),
      .lvl    (btn_lvl[i]),
      .ev     (w_ev[i]),
      .ev_rep (w_ev_rep[i]),
      .held   (btn_held[i])
    );
  end
  // Lowest set pend bit wins: isolate it as a one-hot grant and encode its index
  always_comb begin
    w_gnt = r_pend & (~r_pend + N_BTN'(1));
    w_idx = '0;
    for (int k = N_BTN - 1; k >= 0; k--)
      if (r_pend[k]) w_idx = CODE_W'(k);
  end
  // New events OR in after the grant clears, so a same-edge set keeps the event pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= '0;
      r_pend_rep <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_repeat <= 1'b0;
    end else begin
      r_pend     <= (r_pend & ~w_gnt) | w_ev;
      r_pend_rep <= (r_pend_rep & ~w_ev) | (w_ev_rep & w_ev);
      key_valid  <= |r_pend;
      if (|r_pend) begin
        key_code   <= w_idx;
        key_repeat <= |(r_pend_rep & w_gnt);
      end
    end
  end
endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: directed vector bench for btn_event_gen with N_BTN=5, HOLD_CYC=8, REP_CYC=4
module tb_btn_event_gen;
  localparam int N  = 5;
  localparam int CW = 3;
  localparam int HC = 8;
  localparam int RC = 4;
  localparam int CN = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  btn_lvl = '0;
  logic          key_valid;
  logic [CW-1:0] key_code;
  logic          key_repeat;
  logic [N-1:0]  btn_held;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [N-1:0]  lvl;
    logic          v;
    logic [CW-1:0] c;
    logic          r;
    logic [N-1:0]  h;
    string         nm;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  btn_event_gen #(
    .N_BTN    (N),
    .CODE_W   (CW),
    .HOLD_CYC (HC),
    .REP_CYC  (RC),
    .CNT_W    (CN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_lvl    (btn_lvl),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_repeat (key_repeat),
    .btn_held   (btn_held)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic outs(input string nm, input logic v, input logic [CW-1:0] c, input logic r,
                      input logic [N-1:0] h);
    chk({nm, ".valid"}, 32'(key_valid), 32'(v));
    chk({nm, ".held"}, 32'(btn_held), 32'(h));
    if (v) begin
      chk({nm, ".code"}, 32'(key_code), 32'(c));
      chk({nm, ".repeat"}, 32'(key_repeat), 32'(r));
    end
  endtask
  task automatic add(input string nm, input logic [N-1:0] lvl, input logic v, input logic [CW-1:0] c,
                     input logic r, input logic [N-1:0] h);
    vec_t e;
    e.nm = nm; e.lvl = lvl; e.v = v; e.c = c; e.r = r; e.h = h;
    vecs.push_back(e);
  endtask
  task automatic step(input logic [N-1:0] l);
    btn_lvl = l;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #3;
    outs("reset", 1'b0, '0, 1'b0, '0);
    chk("reset.code", 32'(key_code), 32'd0);
    chk("reset.repeat", 32'(key_repeat), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step('0);
    outs("idle", 1'b0, '0, 1'b0, '0);
    // single short press on button 2
    add("t1e0", 5'b00100, 1'b0, 3'd0, 1'b0, 5'b00100);
    add("t1e1", 5'b00100, 1'b1, 3'd2, 1'b0, 5'b00100);
    add("t1e2", 5'b00100, 1'b0, 3'd0, 1'b0, 5'b00100);
    add("t1e3", 5'b00100, 1'b0, 3'd0, 1'b0, 5'b00100);
    add("t1e4", 5'b00100, 1'b0, 3'd0, 1'b0, 5'b00100);
    add("t1e5", 5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000);
    add("t1e6", 5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000);
    // simultaneous presses on buttons 1 and 3
    add("t3e0", 5'b01010, 1'b0, 3'd0, 1'b0, 5'b01010);
    add("t3e1", 5'b01010, 1'b1, 3'd1, 1'b0, 5'b01010);
    add("t3e2", 5'b01010, 1'b1, 3'd3, 1'b0, 5'b01010);
    add("t3e3", 5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000);
    add("t3e4", 5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000);
    // button 4: 7 high, 1 low, 3 high
    add("t4e0", 5'b10000, 1'b0, 3'd0, 1'b0, 5'b10000);
    add("t4e1", 5'b10000, 1'b1, 3'd4, 1'b0, 5'b10000);
    for (int k = 2; k < 7; k++) add($sformatf("t4e%0d", k), 5'b10000, 1'b0, 3'd0, 1'b0, 5'b10000);
    add("t4e7", 5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000);
    add("t4e8", 5'b10000, 1'b0, 3'd0, 1'b0, 5'b10000);
    add("t4e9", 5'b10000, 1'b1, 3'd4, 1'b0, 5'b10000);
    add("t4e10", 5'b10000, 1'b0, 3'd0, 1'b0, 5'b10000);
    add("t4e11", 5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000);
    add("t4e12", 5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000);
    foreach (vecs[j]) begin
      step(vecs[j].lvl);
      outs(vecs[j].nm, vecs[j].v, vecs[j].c, vecs[j].r, vecs[j].h);
    end
    // button 0 held for edges 0..19: press after E1, repeats after E9, E13, E17
    for (int k = 0; k < 26; k++) begin
      logic ev;
      ev = (k == 1) || (k == 9) || (k == 13) || (k == 17);
      step(k < 20 ? 5'b00001 : 5'b00000);
      outs($sformatf("t2e%0d", k), ev, 3'd0, k != 1, k < 20 ? 5'b00001 : 5'b00000);
    end
    // reset mid WAIT_HOLD while key_valid is high
    step(5'b00001);
    outs("t5e0", 1'b0, 3'd0, 1'b0, 5'b00001);
    step(5'b00001);
    outs("t5e1", 1'b1, 3'd0, 1'b0, 5'b00001);
    #2 rst = 1'b0;
    #1;
    chk("t5async.valid", 32'(key_valid), 32'd0);
    chk("t5async.held", 32'(btn_held), 32'd0);
    @(posedge clk);
    #1;
    outs("t5inrst", 1'b0, 3'd0, 1'b0, 5'b00000);
    rst = 1'b1;
    step(5'b00001);
    outs("t5p0", 1'b0, 3'd0, 1'b0, 5'b00001);
    step(5'b00001);
    outs("t5p1", 1'b1, 3'd0, 1'b0, 5'b00001);
    step(5'b00001);
    outs("t5p2", 1'b0, 3'd0, 1'b0, 5'b00001);
    step(5'b00000);
    outs("t5p3", 1'b0, 3'd0, 1'b0, 5'b00000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
